// File: rtl/xheep_host_run_controller.sv
// Host-side run sequencer for x_heep_system: holds the SoC in reset, releases it, watches exit and reports status.
// Latency: all outputs registered, one cycle from input to output; optional RUN timeout via XHEEP_RUN_CTRL_TIMEOUT_EN.
// Backpressure: none; start_i is accepted only in IDLE/DONE, abort_i is accepted in any state and has priority.
module xheep_host_run_controller #(
    parameter int unsigned RST_CYCLES     = 16,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 boot_select_cfg_i,
    input  logic                 exec_flash_cfg_i,
    input  logic                 exit_valid_i,
    input  logic [31:0]          exit_value_i,
    output logic                 xheep_rst_no,
    output logic                 boot_select_o,
    output logic                 execute_from_flash_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [31:0]          exit_code_o,
    output logic [CNT_WIDTH-1:0] cycle_count_o
);

    localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [RW-1:0]   rst_cnt;
    logic            cnt_max;
    logic            timeout_hit;

    assign cnt_max = &cycle_count_o;

`ifdef XHEEP_RUN_CTRL_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_count_o == TIMEOUT_VAL);
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state                <= S_IDLE;
            rst_cnt              <= '0;
            xheep_rst_no         <= 1'b0;
            boot_select_o        <= 1'b0;
            execute_from_flash_o <= 1'b0;
            busy_o               <= 1'b0;
            done_o               <= 1'b0;
            timeout_o            <= 1'b0;
            exit_code_o          <= '0;
            cycle_count_o        <= '0;
        end else if (abort_i) begin
            // Run results and boot cfg stay visible to the host after an abort.
            state        <= S_IDLE;
            xheep_rst_no <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state                <= S_RESET;
                        rst_cnt              <= RST_LOAD;
                        xheep_rst_no         <= 1'b0;
                        boot_select_o        <= boot_select_cfg_i;
                        execute_from_flash_o <= exec_flash_cfg_i;
                        busy_o               <= 1'b1;
                        done_o               <= 1'b0;
                        timeout_o            <= 1'b0;
                        exit_code_o          <= '0;
                        cycle_count_o        <= '0;
                    end
                end
                S_RESET: begin
                    if (rst_cnt == '0) begin
                        state        <= S_RUN;
                        xheep_rst_no <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    // Exit beats timeout when both land in the same cycle.
                    if (exit_valid_i) begin
                        state       <= S_DONE;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        exit_code_o <= exit_value_i;
                    end else if (timeout_hit) begin
                        state       <= S_DONE;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        timeout_o   <= 1'b1;
                        exit_code_o <= '0;
                    end else if (!cnt_max) begin
                        cycle_count_o <= cycle_count_o + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xheep_host_run_controller.sv
// Self-checking bench for xheep_host_run_controller: randomized runs scored against expectations
// derived from run-phase arithmetic (reset length, RUN cycle counts, captured exit values).
module tb_xheep_host_run_controller;

    localparam int RST = 16;
    localparam int TO  = 1000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        abort_i;
    logic        boot_select_cfg_i;
    logic        exec_flash_cfg_i;
    logic        exit_valid_i;
    logic [31:0] exit_value_i;
    logic        xheep_rst_no;
    logic        boot_select_o;
    logic        execute_from_flash_o;
    logic        busy_o;
    logic        done_o;
    logic        timeout_o;
    logic [31:0] exit_code_o;
    logic [31:0] cycle_count_o;

    int checks   = 0;
    int failures = 0;

    xheep_host_run_controller #(
        .RST_CYCLES    (RST),
        .CNT_WIDTH     (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .start_i             (start_i),
        .abort_i             (abort_i),
        .boot_select_cfg_i   (boot_select_cfg_i),
        .exec_flash_cfg_i    (exec_flash_cfg_i),
        .exit_valid_i        (exit_valid_i),
        .exit_value_i        (exit_value_i),
        .xheep_rst_no        (xheep_rst_no),
        .boot_select_o       (boot_select_o),
        .execute_from_flash_o(execute_from_flash_o),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .timeout_o           (timeout_o),
        .exit_code_o         (exit_code_o),
        .cycle_count_o       (cycle_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic bs, input logic ef);
        boot_select_cfg_i = bs;
        exec_flash_cfg_i  = ef;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Observes the reset phase from its first cycle; pre = reset cycles already stepped by the caller.
    task automatic reset_phase(input string tag, input int pre, input logic bs, input logic ef);
        int n = pre;
        while (xheep_rst_no === 1'b0 && busy_o === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        checks++;
        if (n != RST)
            $display("FAIL %s rst_len got=%0d exp=%0d", tag, n, RST);
        checks++;
        if ({xheep_rst_no, busy_o, boot_select_o, execute_from_flash_o} !== {2'b11, bs, ef})
            $display("FAIL %s run_entry got rst_no/busy/bs/ef=%b%b%b%b exp=11%b%b", tag,
                     xheep_rst_no, busy_o, boot_select_o, execute_from_flash_o, bs, ef);
        if (n != RST || {xheep_rst_no, busy_o, boot_select_o, execute_from_flash_o} !== {2'b11, bs, ef})
            failures++;
    endtask

    // Spends k RUN cycles starting at count base, then raises exit with value v for one cycle.
    task automatic run_to_exit(input string tag, input int base, input int k, input logic [31:0] v,
                               input logic bs, input logic ef);
        int bad = 0;
        for (int i = 0; i < k; i++) begin
            if (xheep_rst_no !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0 ||
                boot_select_o !== bs || execute_from_flash_o !== ef || cycle_count_o !== 32'(base + i))
                bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s run_hold bad_cycles=%0d exp=0", tag, bad);
        end
        exit_valid_i = 1'b1;
        exit_value_i = v;
        tick();
        exit_valid_i = 1'b0;
        exit_value_i = $urandom;
        checks++;
        if ({done_o, busy_o, timeout_o, xheep_rst_no} !== 4'b1001) begin
            failures++;
            $display("FAIL %s done_flags got=%b exp=1001", tag, {done_o, busy_o, timeout_o, xheep_rst_no});
        end
        checks++;
        if (exit_code_o !== v) begin
            failures++;
            $display("FAIL %s exit_code got=%h exp=%h", tag, exit_code_o, v);
        end
        checks++;
        if (cycle_count_o !== 32'(base + k)) begin
            failures++;
            $display("FAIL %s cycle_count got=%0d exp=%0d", tag, cycle_count_o, base + k);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        boot_select_cfg_i = 1'b0; exec_flash_cfg_i = 1'b0;
        exit_valid_i = 1'b0; exit_value_i = '0;
        #12;
        checks++;
        if ({xheep_rst_no, boot_select_o, execute_from_flash_o, busy_o, done_o, timeout_o} !== 6'b0 ||
            exit_code_o !== 32'h0 || cycle_count_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_values flags=%b code=%h cnt=%0d exp all zero",
                     {xheep_rst_no, boot_select_o, execute_from_flash_o, busy_o, done_o, timeout_o},
                     exit_code_o, cycle_count_o);
        end
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 100; i++) begin
            exit_valid_i = $urandom_range(0, 1);
            if (xheep_rst_no !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) bad++;
            tick();
        end
        exit_valid_i = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_hold bad_cycles=%0d exp=0", bad);
        end
    endtask

    task automatic test_basic_run();
        do_start(1'b1, 1'b0);
        reset_phase("basic", 0, 1'b1, 1'b0);
        run_to_exit("basic", 0, 500, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 4; r++) begin
            logic bs = 1'($urandom_range(0, 1));
            logic ef = 1'($urandom_range(0, 1));
            int k = int'($urandom_range(1, 300));
            logic [31:0] v = $urandom | 32'h1;
            do_start(bs, ef);
            checks++;
            if (exit_code_o !== 32'h0 || cycle_count_o !== 32'h0 || done_o !== 1'b0 || busy_o !== 1'b1) begin
                failures++;
                $display("FAIL rand%0d start_clear code=%h cnt=%0d done=%b busy=%b exp 0/0/0/1",
                         r, exit_code_o, cycle_count_o, done_o, busy_o);
            end
            reset_phase("rand", 0, bs, ef);
            run_to_exit("rand", 0, k, v, bs, ef);
        end
    endtask

    task automatic test_done_hold();
        logic bs0 = boot_select_o;
        logic ef0 = execute_from_flash_o;
        int bad = 0;
        for (int i = 0; i < 8; i++) begin
            boot_select_cfg_i = ~boot_select_cfg_i;
            exec_flash_cfg_i  = 1'($urandom_range(0, 1));
            exit_valid_i      = 1'($urandom_range(0, 1));
            tick();
            if (boot_select_o !== bs0 || execute_from_flash_o !== ef0 || xheep_rst_no !== 1'b1 || done_o !== 1'b1)
                bad++;
        end
        exit_valid_i = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL done_hold bad_cycles=%0d exp=0", bad);
        end
        do_start(1'b0, 1'b1);
        checks++;
        if (exit_code_o !== 32'h0 || xheep_rst_no !== 1'b0) begin
            failures++;
            $display("FAIL restart code=%h rst_no=%b exp 0/0", exit_code_o, xheep_rst_no);
        end
        reset_phase("restart", 0, 1'b0, 1'b1);
        run_to_exit("restart", 0, 37, 32'hCAFE_0001, 1'b0, 1'b1);
    endtask

    task automatic test_start_ignored();
        do_start(1'b1, 1'b1);
        start_i = 1'b1; boot_select_cfg_i = 1'b0; exec_flash_cfg_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        start_i = 1'b0;
        reset_phase("ign", 5, 1'b1, 1'b1);
        start_i = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        start_i = 1'b0;
        run_to_exit("ign", 10, 20, 32'h1234_5678, 1'b1, 1'b1);
    endtask

    task automatic test_abort();
        logic [31:0] v = $urandom | 32'h8000_0000;
        do_start(1'b1, 1'b0);
        reset_phase("abort", 0, 1'b1, 1'b0);
        for (int i = 0; i < 200; i++) tick();
        abort_i = 1'b1; start_i = 1'b1;
        tick();
        abort_i = 1'b0; start_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({xheep_rst_no, busy_o, done_o} !== 3'b000 || cycle_count_o !== 32'd200 ||
            {boot_select_o, execute_from_flash_o} !== 2'b10) begin
            failures++;
            $display("FAIL abort_run flags=%b cnt=%0d cfg=%b exp 000/200/10",
                     {xheep_rst_no, busy_o, done_o}, cycle_count_o, {boot_select_o, execute_from_flash_o});
        end
        do_start(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        checks++;
        if ({xheep_rst_no, busy_o, done_o} !== 3'b000) begin
            failures++;
            $display("FAIL abort_reset flags=%b exp=000", {xheep_rst_no, busy_o, done_o});
        end
        do_start(1'b0, 1'b1);
        reset_phase("abort2", 0, 1'b0, 1'b1);
        run_to_exit("abort2", 0, 15, v, 1'b0, 1'b1);
        boot_select_cfg_i = 1'b1; exec_flash_cfg_i = 1'b0;
        start_i = 1'b1; abort_i = 1'b1;
        tick();
        start_i = 1'b0; abort_i = 1'b0;
        tick();
        checks++;
        if ({xheep_rst_no, busy_o, done_o} !== 3'b000 || exit_code_o !== v ||
            {boot_select_o, execute_from_flash_o} !== 2'b01 || cycle_count_o !== 32'd15) begin
            failures++;
            $display("FAIL abort_start flags=%b code=%h cfg=%b cnt=%0d exp 000/%h/01/15",
                     {xheep_rst_no, busy_o, done_o}, exit_code_o,
                     {boot_select_o, execute_from_flash_o}, cycle_count_o, v);
        end
    endtask

    task automatic test_async_reset();
        for (int p = 0; p < 2; p++) begin
            do_start(1'b1, 1'b1);
            if (p == 1) reset_phase("arst", 0, 1'b1, 1'b1);
            for (int i = 0; i < 6; i++) tick();
            #2 rst_ni = 1'b0;
            #1;
            checks++;
            if ({xheep_rst_no, boot_select_o, execute_from_flash_o, busy_o, done_o, timeout_o} !== 6'b0 ||
                exit_code_o !== 32'h0 || cycle_count_o !== 32'h0) begin
                failures++;
                $display("FAIL async_reset%0d flags=%b code=%h cnt=%0d exp all zero", p,
                         {xheep_rst_no, boot_select_o, execute_from_flash_o, busy_o, done_o, timeout_o},
                         exit_code_o, cycle_count_o);
            end
            tick();
            tick();
            rst_ni = 1'b1;
            tick();
        end
        do_start(1'b1, 1'b0);
        reset_phase("post_arst", 0, 1'b1, 1'b0);
        run_to_exit("post_arst", 0, 60, 32'h0, 1'b1, 1'b0);
    endtask

`ifdef XHEEP_RUN_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        do_start(1'b0, 1'b0);
        reset_phase("to", 0, 1'b0, 1'b0);
        for (int i = 0; i < TO; i++) tick();
        tick();
        checks++;
        if ({done_o, busy_o, timeout_o, xheep_rst_no} !== 4'b1011 || exit_code_o !== 32'h0 ||
            cycle_count_o !== 32'(TO)) begin
            failures++;
            $display("FAIL timeout flags=%b code=%h cnt=%0d exp 1011/0/%0d",
                     {done_o, busy_o, timeout_o, xheep_rst_no}, exit_code_o, cycle_count_o, TO);
        end
        do_start(1'b1, 1'b1);
        reset_phase("to_exit", 0, 1'b1, 1'b1);
        run_to_exit("to_exit", 0, TO, 32'hDEAD_BEEF, 1'b1, 1'b1);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_run();
        test_random_runs();
        test_done_hold();
        test_start_ignored();
        test_abort();
        test_async_reset();
`ifdef XHEEP_RUN_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
